// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts one ALU command at a time, strobes the operands to
// the ALU, waits (bounded) for the ALU result and holds it until the consumer
// takes it. ALU results arriving outside the wait window raise a sticky flag.
module alu_cmd_issuer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // command side
  input  logic                  i_cmd_vld,
  output logic                  o_cmd_rdy,
  input  logic [3:0]            i_cmd_op,
  input  logic [1:0]            i_cmd_movi,
  input  logic [DATA_WIDTH-1:0] i_cmd_reg_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_reg_b,
  input  logic [DATA_WIDTH-1:0] i_cmd_mem,
  input  logic [DATA_WIDTH-1:0] i_cmd_imm,
  // ALU side
  output logic                  o_act,
  output logic                  o_alu_rdy,
  output logic [3:0]            o_op,
  output logic [1:0]            o_movi,
  output logic [DATA_WIDTH-1:0] o_reg_a,
  output logic [DATA_WIDTH-1:0] o_reg_b,
  output logic [DATA_WIDTH-1:0] o_mem,
  output logic [DATA_WIDTH-1:0] o_imm,
  input  logic [DATA_WIDTH-1:0] i_ex_alu,
  input  logic                  i_ex_alu_vld,
  // result side
  output logic                  o_res_vld,
  input  logic                  i_res_rdy,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_timeout,
  output logic                  o_stray
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // TIMEOUT is at most 255, so an 8-bit wait counter always suffices.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic                  r_cmd_rdy;
  logic                  r_act;
  logic                  r_alu_rdy;
  logic                  r_res_vld;
  logic                  r_res_timeout;
  logic                  r_stray;
  logic [3:0]            r_op;
  logic [1:0]            r_movi;
  logic [DATA_WIDTH-1:0] r_reg_a;
  logic [DATA_WIDTH-1:0] r_reg_b;
  logic [DATA_WIDTH-1:0] r_mem;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_res_data;

  // Command FSM with registered outputs; every output is updated together
  // with the state transition that defines it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cmd_rdy     <= 1'b0;
      r_act         <= 1'b0;
      r_alu_rdy     <= 1'b0;
      r_res_vld     <= 1'b0;
      r_res_timeout <= 1'b0;
      r_stray       <= 1'b0;
      r_op          <= '0;
      r_movi        <= '0;
      r_reg_a       <= '0;
      r_reg_b       <= '0;
      r_mem         <= '0;
      r_imm         <= '0;
      r_res_data    <= '0;
    end else begin
      // A result strobe is only meaningful while waiting for one.
      if (i_ex_alu_vld && (r_state != ST_WAIT)) begin
        r_stray <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // Ready comes up one cycle after reset release and stays up here.
          r_cmd_rdy <= 1'b1;
          if (r_cmd_rdy && i_cmd_vld) begin
            r_op      <= i_cmd_op;
            r_movi    <= i_cmd_movi;
            r_reg_a   <= i_cmd_reg_a;
            r_reg_b   <= i_cmd_reg_b;
            r_mem     <= i_cmd_mem;
            r_imm     <= i_cmd_imm;
            r_cmd_rdy <= 1'b0;
            r_alu_rdy <= 1'b1;
            r_act     <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Operand strobe lasts exactly one cycle; activity continues.
          r_alu_rdy <= 1'b0;
          r_cnt     <= '0;
          r_state   <= ST_WAIT;
        end

        ST_WAIT: begin
          // A result on the last counted cycle still wins over the timeout.
          if (i_ex_alu_vld) begin
            r_res_data    <= i_ex_alu;
            r_res_timeout <= 1'b0;
            r_res_vld     <= 1'b1;
            r_act         <= 1'b0;
            r_state       <= ST_HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_res_vld     <= 1'b1;
            r_act         <= 1'b0;
            r_state       <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_HOLD: begin
          // Result is held until the consumer takes it, however long that is.
          if (i_res_rdy) begin
            r_res_vld <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_rdy     = r_cmd_rdy;
  assign o_act         = r_act;
  assign o_alu_rdy     = r_alu_rdy;
  assign o_op          = r_op;
  assign o_movi        = r_movi;
  assign o_reg_a       = r_reg_a;
  assign o_reg_b       = r_reg_b;
  assign o_mem         = r_mem;
  assign o_imm         = r_imm;
  assign o_res_vld     = r_res_vld;
  assign o_res_data    = r_res_data;
  assign o_res_timeout = r_res_timeout;
  assign o_stray       = r_stray;

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the operand and result width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, setting the number of wait cycles before a result timeout (legal range 2..255).
REQ-003 The block SHALL have these ports:
  CLK  in  1  single clock, all logic rising-edge
  RST  in  1  reset, asynchronous, active-high
  CMD_VLD  in  1  command valid
  CMD_RDY  out  1  command accepted when high with CMD_VLD
  CMD_OP  in  4  ALU operation code
  CMD_MOVI  in  2  operand-B source select
  CMD_REG_A, CMD_REG_B, CMD_MEM, CMD_IMM  in  DATA_WIDTH each  operand values
  ACT  out  1  ALU activity enable
  ALU_RDY  out  1  operand strobe, one cycle per command
  OP  out  4  operation code to ALU
  MOVI  out  2  operand select to ALU
  REG_A, REG_B, MEM, IMM  out  DATA_WIDTH each  operands to ALU
  EX_ALU  in  DATA_WIDTH  ALU result
  EX_ALU_VLD  in  1  ALU result valid
  RES_VLD  out  1  result valid
  RES_RDY  in  1  result accepted when high with RES_VLD
  RES_DATA  out  DATA_WIDTH  captured result
  RES_TIMEOUT  out  1  qualifies RES_DATA: 1 = no ALU response
  STRAY  out  1  sticky: EX_ALU_VLD seen outside WAIT

Function
REQ-004 The block SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD, with exactly one command outstanding.
REQ-005 IDLE: CMD_RDY=1; on CMD_VLD=1 all CMD_* fields SHALL be registered into OP/MOVI/REG_A/REG_B/MEM/IMM and the state SHALL go to ISSUE.
REQ-006 CMD_RDY SHALL be 0 in ISSUE, WAIT and HOLD (no command accepted while one is outstanding).
REQ-007 ISSUE: ALU_RDY=1 and ACT=1 for exactly one cycle; wait counter cleared to 0; next state WAIT.
REQ-008 WAIT: ACT=1, ALU_RDY=0; if EX_ALU_VLD=1, EX_ALU SHALL be captured into RES_DATA, RES_TIMEOUT set 0, next state HOLD.
REQ-009 WAIT without EX_ALU_VLD: counter increments; when counter equals TIMEOUT-1 and EX_ALU_VLD=0, RES_DATA SHALL be set to 0, RES_TIMEOUT to 1, next state HOLD.
REQ-010 Simultaneous EX_ALU_VLD=1 and counter=TIMEOUT-1 SHALL be treated as a valid result (RES_TIMEOUT=0).
REQ-011 HOLD: RES_VLD=1, ACT=0; RES_DATA/RES_TIMEOUT stable; on RES_RDY=1 next state IDLE; RES_RDY low SHALL hold indefinitely.
REQ-012 RES_VLD SHALL be 0 in IDLE, ISSUE and WAIT.
REQ-013 ALU-side OP/MOVI/REG_A/REG_B/MEM/IMM SHALL remain stable from ISSUE until the next accepted command.
REQ-014 EX_ALU_VLD=1 in IDLE, ISSUE or HOLD SHALL be ignored for data and SHALL set STRAY=1; STRAY clears only on reset.
REQ-015 Latency: command accepted at edge N -> ALU_RDY high in cycle N+1 -> earliest EX_ALU_VLD sampled cycle N+2 -> RES_VLD high cycle N+3.
REQ-016 Back-to-back: RES_RDY accepted at edge M -> CMD_RDY high in cycle M+1; minimum command period 4 cycles.

Reset
REQ-017 RST=1 SHALL immediately force state IDLE, counter 0, and outputs CMD_RDY=0, ACT=0, ALU_RDY=0, RES_VLD=0, RES_TIMEOUT=0, STRAY=0, OP/MOVI/REG_A/REG_B/MEM/IMM/RES_DATA=0.
REQ-018 CMD_RDY SHALL rise in the first cycle after RST deasserts.
REQ-019 RST during ISSUE, WAIT or HOLD SHALL abort the command with no RES_VLD generated; a late EX_ALU_VLD after reset SHALL only set STRAY.

Verification
REQ-020 Basic: CMD_OP=4'h1, REG_A=8'h12, REG_B=8'h34, ALU responds EX_ALU=8'h46 two cycles after ALU_RDY, RES_RDY=1 -> RES_VLD one cycle, RES_DATA=8'h46, RES_TIMEOUT=0, CMD_RDY back next cycle.
REQ-021 Timeout: command issued, EX_ALU_VLD never asserted, TIMEOUT=16 -> RES_VLD rises 17 cycles after ALU_RDY, RES_DATA=0, RES_TIMEOUT=1.
REQ-022 Boundary: EX_ALU_VLD=1 with EX_ALU=8'hFF exactly on counter=15 -> RES_DATA=8'hFF, RES_TIMEOUT=0.
REQ-023 Backpressure: RES_RDY=0 for 10 cycles with CMD_VLD=1 held -> RES_VLD/RES_DATA stable, CMD_RDY=0 throughout, second command accepted one cycle after RES_RDY=1.
REQ-024 Stray/reset: EX_ALU_VLD pulse in IDLE -> STRAY=1, no RES_VLD; RST pulse in WAIT -> all outputs 0, later EX_ALU_VLD produces no RES_VLD.
